// File: rtl/fpdiv_seq_if.sv
// Request/result bundle for the sequential fixed-point divider.
// The master drives the request fields; the slave (the divider) drives status and result.
interface fpdiv_seq_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient_out;
    logic         complete;
    logic         busy;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient_out, complete, busy, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient_out, complete, busy, div_by_zero, overflow
    );
endinterface

// File: rtl/fpdiv_seq.sv
// Sequential sign-magnitude fixed-point divider: restoring division, one quotient bit
// per clock, with saturation on overflow and an all-ones result on divide by zero.
module fpdiv_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    fpdiv_seq_if.slave   bus
);
    localparam int ITERS = N - 1 + Q;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [N-2:0]   r_dvs;
    logic [N-2:0]   r_rem;
    logic [ITERS-1:0] r_work;
    logic [CW-1:0]  r_cnt;
    logic           r_sign;
    logic [N-1:0]   r_quot;
    logic           r_dbz;
    logic           r_ovf;

    logic [N-1:0]   w_trial;
    logic           w_ge;
    logic [N-2:0]   w_diff;
    logic [ITERS-1:0] w_quot;
    logic           w_ovf;
    logic [N-2:0]   w_mag;
    logic           w_sign_res;
    logic           w_last;
    logic           w_dvs_zero;

    // The partial remainder is always below the divisor, so the shifted trial fits in N bits
    // and the difference, when taken, fits back in N-1 bits.
    assign w_trial    = {r_rem, r_work[ITERS-1]};
    assign w_ge       = (w_trial >= {1'b0, r_dvs});
    assign w_diff     = w_trial[N-2:0] - r_dvs;
    assign w_quot     = {r_work[ITERS-2:0], w_ge};
    assign w_last     = (r_cnt == CW'(ITERS - 1));
    assign w_dvs_zero = (r_dvs == '0);

    generate
        if (Q > 0) begin : g_ovf
            assign w_ovf = |w_quot[ITERS-1:N-1];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    assign w_mag      = w_ovf ? '1 : w_quot[N-2:0];
    assign w_sign_res = r_sign & (|w_mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_CALC;
            S_CALC:  if (w_dvs_zero || w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.complete     = (r_state == S_DONE);
        bus.busy         = (r_state != S_IDLE);
        bus.quotient_out = r_quot;
        bus.div_by_zero  = r_dbz;
        bus.overflow     = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvs  <= '0;
            r_rem  <= '0;
            r_work <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_quot <= '0;
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dvs  <= bus.divisor[N-2:0];
                        r_work <= ITERS'(bus.dividend[N-2:0]) << Q;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_sign <= bus.dividend[N-1] ^ bus.divisor[N-1];
                    end
                end
                S_CALC: begin
                    if (w_dvs_zero) begin
                        r_quot <= {r_sign, {(N-1){1'b1}}};
                        r_dbz  <= 1'b1;
                        r_ovf  <= 1'b0;
                    end else begin
                        r_rem  <= w_ge ? w_diff : w_trial[N-2:0];
                        r_work <= w_quot;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_quot <= {w_sign_res, w_mag};
                            r_dbz  <= 1'b0;
                            r_ovf  <= w_ovf;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fpdiv_seq.md
FPDIV_SEQ -- requirements
Module: fpdiv_seq

Interface
REQ-001 The block SHALL have parameter Q, default 15, number of fractional bits of the operand/result format.
REQ-002 The block SHALL have parameter N, default 32, total word width (bit N-1 = sign, bits N-2:0 = magnitude; sign-magnitude fixed point).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a divide, sampled only in IDLE.
REQ-006 The block SHALL have port dividend, input, N bits: numerator, sampled on the accepting edge.
REQ-007 The block SHALL have port divisor, input, N bits: denominator, sampled on the accepting edge.
REQ-008 The block SHALL have port quotient_out, output, N bits: registered result, held until the next completion.
REQ-009 The block SHALL have port complete, output, 1 bit: one-cycle pulse marking quotient_out valid.
REQ-010 The block SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: status of last operation, updated with complete.
REQ-012 The block SHALL have port overflow, output, 1 bit: status of last operation, updated with complete.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE.
REQ-014 IDLE + start=1 at edge E0 SHALL latch |dividend|, |divisor|, sign = dividend[N-1] XOR divisor[N-1], and enter CALC.
REQ-015 Divisor magnitude zero at E0 SHALL skip iteration: at E1 enter DONE, quotient_out = {sign, all-ones magnitude}, div_by_zero=1, overflow=0.
REQ-016 CALC SHALL perform a restoring divide of (|dividend| << Q) by |divisor|, one quotient bit per edge, N-1+Q iterations (46 by default), MSB first.
REQ-017 The last iteration edge (E46 by default) SHALL register the result, set complete=1 and enter DONE; complete is high for exactly the cycle after that edge.
REQ-018 Quotient magnitude SHALL be truncated toward zero; remainder is discarded.
REQ-019 Full quotient magnitude exceeding 2^(N-1)-1 SHALL saturate the magnitude to all-ones, keep the computed sign, and set overflow=1.
REQ-020 Zero quotient magnitude SHALL force the sign bit to 0 (no negative zero).
REQ-021 DONE SHALL return to IDLE on the next edge unconditionally; complete drops on that edge.
REQ-022 start SHALL be ignored in CALC and DONE; a new operation is accepted no earlier than the first edge in IDLE (back-to-back spacing = latency + 1 edges).
REQ-023 Input changes after E0 SHALL have no effect on the operation in progress.
REQ-024 div_by_zero and overflow SHALL be mutually exclusive and hold their values until the next completion.

Reset
REQ-025 rst=1 at any edge, including mid-CALC, SHALL force IDLE, quotient_out=0, complete=0, busy=0, div_by_zero=0, overflow=0, and abandon the operation with no complete pulse.
REQ-026 rst SHALL take priority over start on the same edge.

Verification
REQ-027 Basic: dividend 0x00030000 (6.0), divisor 0x00010000 (2.0), start at E0 -> complete at cycle after E46, quotient_out 0x00018000, both flags 0.
REQ-028 Sign and truncation: 0x8000C000 / 0x00004000 -> 0x80018000; 0x00008000 / 0x00018000 -> 0x00002AAA; 0x80000001 / 0x00008000 -> 0x00000001 with sign bit set (0x80000001).
REQ-029 Divide by zero: 0x80008000 / 0x00000000 -> complete at cycle after E1, quotient_out 0xFFFFFFFF, div_by_zero=1.
REQ-030 Overflow: 0x7FFFFFFF / 0x00000001 -> quotient_out 0x7FFFFFFF, overflow=1; then 0x00000000 / 0x00008000 -> 0x00000000, flags cleared.
REQ-031 Reset mid-op: start 6.0/2.0, assert rst at E20 -> no complete pulse, all outputs 0, busy 0; new start at E22 completes normally at cycle after E68.
REQ-032 Protocol: start held high continuously -> operations accepted every 48 edges, exactly one complete pulse each; start pulses during CALC/DONE produce no extra completions.
